// File: rtl/timer_pkg.sv
// timer_pkg: shared prescaler divisors and width helper for the interval timers
package timer_pkg;
   localparam int DIV_100MS_50MHZ = 5000000;
   localparam int DIV_1MS_50MHZ = 50000;
   function automatic int width_of(input int v);
      int w = 1;
      while ((2 ** w) < v) w++;
      return w;
   endfunction
endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler: divides clk by DIV into a one-cycle base tick while run is high
module tick_prescaler #(
   parameter int DIV = 4,
   parameter int DIV_W = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic run,
   input  logic clear,
   output logic tick
);
   localparam logic [DIV_W-1:0] LAST = DIV_W'(DIV - 1);
   logic [DIV_W-1:0] pre;
   assign tick = run && (pre == LAST);
   always_ff @(posedge clk or negedge rst)
      if (!rst) pre <= '0;
      else if (clear || tick) pre <= '0;
      else if (run) pre <= pre + 1'b1;
endmodule

// File: rtl/prog_interval_timer.sv
// prog_interval_timer: programmable one-shot/periodic timeout counter over a prescaled tick
module prog_interval_timer
   import timer_pkg::*;
#(
   parameter int DIV = DIV_100MS_50MHZ,
   parameter int CNT_W = 8,
   parameter int DEFAULT_TERM = 5
) (
   input  logic clk,
   input  logic rst,
   input  logic enable,
   input  logic restart,
   input  logic periodic,
   input  logic [CNT_W-1:0] terminal,
   output logic timeout,
   output logic expired,
   output logic running,
   output logic [CNT_W-1:0] count
);
   localparam int DIV_W = width_of(DIV);
   logic [CNT_W-1:0] term_q, term_next;
   logic tick, wrap;
   assign running = enable && !expired;
   assign term_next = (terminal == '0) ? CNT_W'(1) : terminal;
   assign wrap = tick && (count == term_q - 1'b1);
   tick_prescaler #(.DIV(DIV), .DIV_W(DIV_W)) u_pre (
      .clk(clk), .rst(rst), .run(running), .clear(restart), .tick(tick)
   );
   // restart wins over a coincident terminal tick, so that timeout is dropped
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         timeout <= 1'b0;
         expired <= 1'b0;
         count <= '0;
         term_q <= CNT_W'(DEFAULT_TERM);
      end else if (restart) begin
         timeout <= 1'b0;
         expired <= 1'b0;
         count <= '0;
         term_q <= term_next;
      end else begin
         timeout <= wrap;
         if (wrap) begin
            count <= '0;
            term_q <= term_next;
            expired <= !periodic;
         end else if (tick) count <= count + 1'b1;
      end
endmodule

// File: tb/tb_prog_interval_timer.sv
// tb_prog_interval_timer: directed timing checks plus an enabled-edge model compared every cycle
module tb_prog_interval_timer;
   localparam int DIV = 4;
   localparam int CNT_W = 4;
   localparam int DEFAULT_TERM = 5;
   logic clk = 1'b0;
   logic rst = 1'b0;
   logic enable = 1'b0;
   logic restart = 1'b0;
   logic periodic = 1'b1;
   logic [CNT_W-1:0] terminal = 4'd3;
   logic timeout, expired, running;
   logic [CNT_W-1:0] count;
   int vectors = 0;
   int miscompares = 0;
   int m_e = 0;
   int m_term = DEFAULT_TERM;
   logic m_exp = 1'b0;
   logic m_to = 1'b0;

   prog_interval_timer #(.DIV(DIV), .CNT_W(CNT_W), .DEFAULT_TERM(DEFAULT_TERM)) dut (
      .clk(clk), .rst(rst), .enable(enable), .restart(restart), .periodic(periodic),
      .terminal(terminal), .timeout(timeout), .expired(expired), .running(running), .count(count)
   );

   always #5 clk = ~clk;

   function automatic int tn();
      return (terminal == '0) ? 1 : int'(terminal);
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, want %0d", name, act, exp);
      end
   endtask

   // model: count enabled edges in the current period; a period lasts term*DIV of them
   always @(posedge clk or negedge rst)
      if (!rst) begin
         m_e <= 0;
         m_term <= DEFAULT_TERM;
         m_exp <= 1'b0;
         m_to <= 1'b0;
      end else if (restart) begin
         m_e <= 0;
         m_term <= tn();
         m_exp <= 1'b0;
         m_to <= 1'b0;
      end else if (enable && !m_exp && (m_e + 1 == m_term * DIV)) begin
         m_e <= 0;
         m_term <= tn();
         m_exp <= !periodic;
         m_to <= 1'b1;
      end else begin
         m_to <= 1'b0;
         if (enable && !m_exp) m_e <= m_e + 1;
      end

   always @(negedge clk) begin
      chk("timeout", int'(timeout), int'(m_to));
      chk("expired", int'(expired), int'(m_exp));
      chk("running", int'(running), int'(enable && !m_exp));
      chk("count", int'(count), m_e / DIV);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_restart();
      restart = 1'b1;
      step();
      restart = 1'b0;
   endtask

   task automatic wait_to(input string name, input int exp);
      int n = 0;
      do begin
         step();
         n++;
      end while (!timeout && n < 64);
      chk(name, n, exp);
   endtask

   initial begin
      #2;
      chk("rst_timeout", int'(timeout), 0);
      chk("rst_expired", int'(expired), 0);
      chk("rst_count", int'(count), 0);
      chk("rst_running_lo", int'(running), 0);
      enable = 1'b1;
      #1;
      chk("rst_running_hi", int'(running), 1);
      step();
      rst = 1'b1;
      do_restart();
      wait_to("per_first", 12);
      wait_to("per_second", 12);
      repeat (4) step();
      chk("per_cnt_mid", int'(count), 1);
      wait_to("per_third", 8);
      periodic = 1'b0;
      do_restart();
      wait_to("os_first", 12);
      chk("os_expired", int'(expired), 1);
      chk("os_running", int'(running), 0);
      repeat (20) step();
      chk("os_hold_cnt", int'(count), 0);
      chk("os_hold_exp", int'(expired), 1);
      do_restart();
      chk("os_restart_exp", int'(expired), 0);
      wait_to("os_again", 12);
      periodic = 1'b1;
      do_restart();
      repeat (6) step();
      enable = 1'b0;
      repeat (5) step();
      chk("pause_cnt", int'(count), 1);
      enable = 1'b1;
      wait_to("pause_rest", 6);
      do_restart();
      repeat (5) step();
      terminal = 4'd5;
      wait_to("term_cur", 7);
      wait_to("term_next", 20);
      terminal = 4'd0;
      do_restart();
      wait_to("term0_a", 4);
      wait_to("term0_b", 4);
      terminal = 4'd3;
      do_restart();
      repeat (11) step();
      restart = 1'b1;
      step();
      chk("coll_timeout", int'(timeout), 0);
      chk("coll_count", int'(count), 0);
      restart = 1'b0;
      wait_to("coll_next", 12);
      do_restart();
      repeat (7) step();
      chk("arst_pre_cnt", int'(count), 1);
      #2 rst = 1'b0;
      #1;
      chk("arst_count", int'(count), 0);
      chk("arst_timeout", int'(timeout), 0);
      chk("arst_expired", int'(expired), 0);
      terminal = 4'd7;
      step();
      rst = 1'b1;
      wait_to("arst_default", 20);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/prog_interval_timer.md
Name: prog_interval_timer

Overview:
- Parametrised interval timer; successor of the fixed 500 ms timer.
- An internal prescaler derives a base tick from clk. A main counter counts ticks up to a run-time-programmable terminal value, then emits a one-cycle timeout.
- Supports one-shot and periodic modes, pause/resume via enable, synchronous restart, and a sticky expired flag.
- Used by the pattern-matching control FSMs for display and entry timeouts.

Parameters:
DIV, 5000000, clk cycles per base tick (100 ms at 50 MHz); legal range DIV >= 1
CNT_W, 8, width of the tick counter and terminal value
DEFAULT_TERM, 5, terminal value loaded at reset; must fit CNT_W and be >= 1
DIV_W, clog2(DIV) (min 1), localparam, prescaler width; not user-set

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-low reset
enable  in  1  count while high; pause (hold state) while low
restart  in  1  synchronous one-cycle pulse; clears and reloads
periodic  in  1  1 = auto-reload after timeout; 0 = one-shot
terminal  in  CNT_W  base ticks per timeout; 0 treated as 1
timeout  out  1  one-cycle pulse at each terminal count
expired  out  1  sticky; set on one-shot timeout
running  out  1  enable && !expired
count  out  CNT_W  base ticks elapsed in the current period

Behaviour:
- Reset (rst=0, asynchronous):
  - timeout=0, expired=0, count=0, prescaler=0.
  - Shadow terminal register term_q=DEFAULT_TERM.
  - running follows enable.
- Prescaler:
  - Increments on each clock edge where running=1.
  - tick = running && (pre == DIV-1), combinational.
  - On tick, pre wraps to 0. With DIV=1, tick=running.
- Main counter:
  - On tick and count != term_q-1: count increments.
  - On tick and count == term_q-1: count->0 and timeout<=1 for exactly one cycle. term_q is re-sampled from terminal at this edge (0 -> 1).
- Latency:
  - With restart released and enable held high, the first timeout is visible in the cycle after the (term_q*DIV)-th enabled rising edge.
  - Periodic mode then repeats every term_q*DIV enabled cycles.
- One-shot (periodic=0 at the timeout edge):
  - expired<=1 on the same edge timeout<=1. running drops.
  - Prescaler and count freeze at 0 until restart. enable has no effect while expired=1.
- Periodic: expired never sets. Counting continues seamlessly with no dead cycle.
- enable low: pre and count hold; no tick is generated. Re-asserting enable resumes mid-period.
- restart=1:
  - pre=0, count=0, expired=0, timeout=0 next cycle.
  - term_q<=terminal (0 -> 1).
  - Overrides a coincident tick/timeout; that timeout is lost.
- terminal is otherwise ignored mid-period. Changes take effect only at restart or the next timeout.
- Mode: periodic is sampled only at the timeout edge.
- Reset mid-operation aborts immediately. After rst release the block counts from 0 using DEFAULT_TERM.
- All outputs are registered except running (combinational from enable and expired).

Decomposition:
- Shared package timer_pkg:
  - default DIV values per board clock (e.g. DIV_100MS_50MHZ, DIV_1MS_50MHZ).
  - A clog2-style width constant function.
- Sub-module tick_prescaler:
  - Parameters DIV, DIV_W.
  - Ports clk, rst, run, clear → tick.
  - Holds the prescaler counter and wrap logic.
- The top level holds term_q, count, the timeout/expired registers, and mode logic.

Test Plan:
- DIV=4, CNT_W=4, terminal=3, periodic=1, enable held high after reset → timeout pulses one cycle after enabled edges 12, 24, 36; count sequence per period 0,1,2.
- Same setup, periodic=0 → single timeout after edge 12, expired=1, running=0; count stays 0 for 20 further cycles; restart pulse → expired=0, next timeout 12 enabled edges later.
- Periodic, enable dropped for 5 cycles at edge 6 → pre/count hold; timeout shifts from edge 12 to edge 17.
- terminal changed 3→5 mid-period → current period still ends at 12 edges; the following period is 20 edges. terminal=0 with restart → timeout every 4 edges.
- restart asserted in the exact cycle of the terminal tick → no timeout pulse; count=0, pre=0; next timeout 12 edges later.
- rst asserted asynchronously mid-count (between edges) → all outputs clear immediately without a clock; after release with terminal ignored, timeout after 5*4=20 edges (DEFAULT_TERM).
